window_buffer: RTL and testbench
================================

Name: window_buffer

Overview:
- Streaming line-buffer and window generator that sits directly upstream of the convolution filter stage.
- Accepts one pixel per channel per handshake in raster order.
- Stores KernelWidth-1 previous image rows per channel.
- Emits a full KernelWidth x KernelWidth window per channel, laid out for the filter's windows_i input, for every valid (unpadded) kernel position.

Parameters:
- WidthIn, 1, bits per pixel per channel.
- KernelWidth, 3, kernel side length; KernelArea = KernelWidth*KernelWidth (localparam).
- InChannels, 1, number of parallel channels sharing one handshake.
- ImageWidth, 32, pixels per row; must be >= KernelWidth.
- ImageHeight, 32, rows per frame; must be >= KernelWidth.

Ports:
- clk_i  input  1  clock
- rst_ni  input  1  asynchronous active-low reset
- valid_i  input  1  input pixel valid
- ready_o  output  1  input pixel accepted when valid_i && ready_o
- data_i  input  [InChannels-1:0][WidthIn-1:0]  one pixel per channel
- valid_o  output  1  windows_o valid
- ready_i  input  1  downstream ready
- windows_o  output  [InChannels-1:0][KernelArea-1:0][WidthIn-1:0]  window per channel
- last_o  output  1  marks the final window of a frame

Behaviour:
- Reset:
  - Asynchronous on rst_ni low.
  - valid_o=0, last_o=0, windows_o=0, column/row counters=0.
  - Line-buffer RAM contents are not reset; stale data is never exposed, because output is gated by the counters.
- Handshake:
  - ready_o = !valid_o || ready_i (single output register, no skid).
  - Input accept (acc) = valid_i && ready_o.
  - Output transfer = valid_o && ready_i.
  - windows_o and last_o are held stable while valid_o && !ready_i.
- Counters:
  - col counts 0..ImageWidth-1; row counts 0..ImageHeight-1; both advance only on acc.
  - col wraps to 0 and row increments.
  - At (ImageHeight-1, ImageWidth-1) both wrap to 0; the next frame follows back-to-back with no gap cycle.
- Storage:
  - Per channel, KernelWidth-1 row buffers of ImageWidth entries, addressed by col.
  - On acc, row buffers shift vertically at column col; the new pixel enters the bottom line.
  - Window shift registers shift left by one column, loading the KernelWidth-high column formed by the buffered pixels at col plus the new pixel.
  - Shifting continues across row boundaries; the resulting invalid windows are suppressed, not flushed.
- Window layout:
  - Element index r*KernelWidth+c.
  - r=0 is the oldest (top) row; c=0 is the leftmost (oldest) column.
  - Index KernelArea-1 is the pixel just accepted.
- Output generation:
  - On acc with row >= KernelWidth-1 and col >= KernelWidth-1 (the pre-increment position of the accepted pixel):
    - valid_o <= 1 on the next edge.
    - windows_o loaded with the updated window.
    - last_o <= (row==ImageHeight-1 && col==ImageWidth-1).
  - Otherwise, on an output transfer without a qualifying acc: valid_o <= 0, last_o <= 0.
  - Latency: one cycle from the accepting edge to valid_o.
  - With ready_i held high, the block sustains one window per cycle.
- Window counts:
  - Valid windows per frame = (ImageWidth-KernelWidth+1)*(ImageHeight-KernelWidth+1).
  - Exactly one window per frame has last_o=1.
- Simultaneous events: when an output transfer and a qualifying acc occur on the same edge, valid_o stays 1 and the new window replaces the old one.
- Reset mid-frame:
  - Counters and valid_o return to 0.
  - The next accepted pixel is treated as (0,0) of a new frame.
  - No window containing pre-reset pixels is emitted.
- Channels share counters and handshake; channel data never mixes.
- Window registers pass straight to the filter; no arithmetic is performed in this block.

Test Plan:
- ImageWidth=ImageHeight=4, KernelWidth=3, InChannels=1, WidthIn=8, pixels 0..15, ready_i=1:
  - exactly 4 windows;
  - first window indices 0..8 = {0,1,2,4,5,6,8,9,10};
  - last window = {5,6,7,9,10,11,13,14,15} with last_o=1;
  - each valid_o exactly one cycle after the accepting edge.
- Same stream with ready_i low for 3 cycles while valid_o=1:
  - windows_o and last_o stable; ready_o=0;
  - no pixels lost;
  - window sequence identical to the first test.
- Random valid_i bubbles (50%):
  - same 4 windows in the same order;
  - a window is never emitted during a row's first KernelWidth-1 columns.
- Two frames back-to-back, second frame pixel = 100+index:
  - 8 windows total;
  - fifth window = {100,101,102,104,105,106,108,109,110};
  - no window mixes frame-1 and frame-2 pixels.
- InChannels=2, channel1 = 255-channel0 pixel:
  - each channel1 window equals the element-wise complement of the channel0 window.
- Assert rst_ni low after 9 pixels, release, then send a full frame of 0..15:
  - outputs 0 during reset;
  - afterwards, exactly the 4 windows from the first test.

Source files
------------

// File: rtl/window_buffer.sv
// Streaming line buffer and KernelWidth x KernelWidth window generator feeding the
// convolution filter; one window per channel per valid kernel position.
module window_buffer #(
  parameter int unsigned WidthIn     = 1,
  parameter int unsigned KernelWidth = 3,
  parameter int unsigned InChannels  = 1,
  parameter int unsigned ImageWidth  = 32,
  parameter int unsigned ImageHeight = 32,
  localparam int unsigned KernelArea = KernelWidth * KernelWidth
) (
  input  logic                                             clk_i,
  input  logic                                             rst_ni,
  input  logic                                             valid_i,
  output logic                                             ready_o,
  input  logic [InChannels-1:0][WidthIn-1:0]               data_i,
  output logic                                             valid_o,
  input  logic                                             ready_i,
  output logic [InChannels-1:0][KernelArea-1:0][WidthIn-1:0] windows_o,
  output logic                                             last_o
);

  localparam int unsigned ColW = (ImageWidth > 1) ? $clog2(ImageWidth) : 1;
  localparam int unsigned RowW = (ImageHeight > 1) ? $clog2(ImageHeight) : 1;

  logic [ColW-1:0] col_q, col_d;
  logic [RowW-1:0] row_q, row_d;
  logic            valid_q, valid_d;
  logic            last_q, last_d;
  logic            acc, xfer, col_end, row_end, fire_win;

  assign ready_o  = !valid_q || ready_i;
  assign acc      = valid_i && ready_o;
  assign xfer     = valid_q && ready_i;
  assign col_end  = (col_q == ColW'(ImageWidth - 1));
  assign row_end  = (row_q == RowW'(ImageHeight - 1));
  // Positions are judged before the counters advance for this pixel.
  assign fire_win = acc && (row_q >= RowW'(KernelWidth - 1)) && (col_q >= ColW'(KernelWidth - 1));

  always_comb begin
    col_d   = col_q;
    row_d   = row_q;
    valid_d = valid_q;
    last_d  = last_q;
    if (acc) begin
      if (col_end) begin
        col_d = '0;
        row_d = row_end ? '0 : row_q + RowW'(1);
      end else begin
        col_d = col_q + ColW'(1);
      end
    end
    if (fire_win) begin
      valid_d = 1'b1;
      last_d  = row_end && col_end;
    end else if (xfer) begin
      valid_d = 1'b0;
      last_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      col_q   <= '0;
      row_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  assign valid_o = valid_q;
  assign last_o  = last_q;

  for (genvar gi = 0; gi < InChannels; gi++) begin : g_ch
    // Row 0 holds the oldest buffered line; the incoming pixel completes the column.
    logic [WidthIn-1:0]                              line_mem [KernelWidth-1][ImageWidth];
    logic [KernelWidth-1:0][WidthIn-1:0]             column;
    logic [KernelWidth-1:0][KernelWidth-1:0][WidthIn-1:0] win_q, win_d;
    logic [KernelArea-1:0][WidthIn-1:0]              out_q;

    always_comb begin
      for (int r = 0; r < KernelWidth - 1; r++) begin
        column[r] = line_mem[r][col_q];
      end
      column[KernelWidth-1] = data_i[gi];
    end

    always_comb begin
      for (int r = 0; r < KernelWidth; r++) begin
        win_d[r] = {column[r], win_q[r][KernelWidth-1:1]};
      end
    end

    always_ff @(posedge clk_i) begin
      if (acc) begin
        for (int r = 0; r < KernelWidth - 2; r++) begin
          line_mem[r][col_q] <= line_mem[r+1][col_q];
        end
        line_mem[KernelWidth-2][col_q] <= data_i[gi];
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        win_q <= '0;
        out_q <= '0;
      end else begin
        if (acc) begin
          win_q <= win_d;
        end
        if (fire_win) begin
          out_q <= win_d;
        end
      end
    end

    assign windows_o[gi] = out_q;
  end

endmodule

// File: tb/tb_window_buffer.sv
// Scoreboard bench for window_buffer on a 4x4 image, 3x3 kernel, two channels
// (channel 1 carries 255 minus the channel 0 pixel).
module tb_window_buffer;
  localparam int W = 8, KW = 3, CH = 2, IW = 4, IH = 4, KA = KW * KW;
  localparam int VW = CH * KA * W;

  logic clk_i = 1'b0, rst_ni = 1'b0, valid_i = 1'b0, ready_i = 1'b1;
  logic ready_o, valid_o, last_o;
  logic [CH-1:0][W-1:0] data_i = '0;
  logic [CH-1:0][KA-1:0][W-1:0] windows_o;

  window_buffer #(.WidthIn(W), .KernelWidth(KW), .InChannels(CH),
                  .ImageWidth(IW), .ImageHeight(IH)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i), .ready_o(ready_o),
    .data_i(data_i), .valid_o(valid_o), .ready_i(ready_i),
    .windows_o(windows_o), .last_o(last_o));

  always #5 clk_i = ~clk_i;

  typedef struct { logic [VW-1:0] win; logic last; int cyc; } exp_t;
  exp_t q[$];
  logic [KA*W-1:0] got[$];
  logic got_last[$];
  int total = 0, bad = 0, cyc = 0, acc_count = 0, mrow = 0, mcol = 0;
  bit head_seen = 0;

  byte unsigned w_first[9] = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
  byte unsigned w_last[9]  = '{5, 6, 7, 9, 10, 11, 13, 14, 15};

  function automatic logic [KA*W-1:0] pack9(input byte unsigned v[9], input int off);
    logic [KA*W-1:0] r;
    for (int k = 0; k < KA; k++) r[k*W +: W] = 8'(int'(v[k]) + off);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s act=%0h req=%0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  always @(posedge clk_i) cyc <= cyc + 1;

  // Stimulus-side model: predicts the window for each pixel the DUT will accept next edge.
  always @(negedge clk_i) begin
    if (!rst_ni) begin
      mrow = 0; mcol = 0; q.delete();
    end else if (valid_i && ready_o) begin
      acc_count++;
      if (mrow >= KW - 1 && mcol >= KW - 1) begin
        exp_t e;
        int base;
        base = int'(data_i[0]) - (mrow * IW + mcol);
        for (int r = 0; r < KW; r++)
          for (int c = 0; c < KW; c++) begin
            int v;
            v = base + (mrow - (KW - 1) + r) * IW + (mcol - (KW - 1) + c);
            e.win[(r*KW + c)*W +: W]      = 8'(v);
            e.win[KA*W + (r*KW + c)*W +: W] = 8'(255 - v);
          end
        e.last = (mrow == IH - 1) && (mcol == IW - 1);
        e.cyc  = cyc + 1;
        q.push_back(e);
      end
      if (mcol == IW - 1) begin
        mcol = 0;
        mrow = (mrow == IH - 1) ? 0 : mrow + 1;
      end else begin
        mcol++;
      end
    end
  end

  always @(negedge clk_i) begin
    if (!rst_ni) begin
      head_seen = 0;
    end else begin
      if (valid_o && !head_seen) begin
        if (q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_window act=%0h req=none (t=%0t)", windows_o, $time);
        end else begin
          chk("latency", VW'(cyc), VW'(q[0].cyc));
          head_seen = 1;
        end
      end
      if (valid_o && ready_i && q.size() > 0) begin
        chk("window", windows_o, q[0].win);
        chk("last", VW'(last_o), VW'(q[0].last));
        $display("window %0d last=%0b ch0=%0h", got.size(), last_o, windows_o[0]);
        got.push_back(windows_o[0]);
        got_last.push_back(last_o);
        void'(q.pop_front());
        head_seen = 0;
      end
    end
  end

  task automatic send(input int v, input int gap);
    int n, b;
    valid_i = 1'b0;
    repeat (gap) begin @(posedge clk_i); #1; end
    data_i[0] = 8'(v);
    data_i[1] = 8'(255 - v);
    valid_i = 1'b1;
    n = acc_count;
    b = 0;
    while (acc_count == n) begin
      @(posedge clk_i); #1;
      b++;
      if (b > 50) begin
        total++; bad++;
        $display("FAIL accept_timeout act=waiting req=accepted pixel=%0d", v);
        break;
      end
    end
    valid_i = 1'b0;
  endtask

  task automatic frame(input int base, input bit bubbles);
    for (int p = 0; p < IW * IH; p++) send(base + p, bubbles ? int'($urandom_range(0, 1)) : 0);
  endtask

  task automatic drain_and_check(input string t, input int n);
    repeat (6) begin @(posedge clk_i); #1; end
    chk({t, "_drain"}, VW'(q.size()), VW'(0));
    chk({t, "_count"}, VW'(got.size()), VW'(n));
    chk({t, "_first"}, VW'(got[0]), VW'(pack9(w_first, 0)));
    chk({t, "_firstflag"}, VW'(got_last[0]), VW'(0));
    chk({t, "_lastwin"}, VW'(got[3]), VW'(pack9(w_last, 0)));
    chk({t, "_lastflag"}, VW'(got_last[3]), VW'(1));
  endtask

  task automatic check_reset_outputs(input string t);
    @(negedge clk_i);
    chk({t, "_valid"}, VW'(valid_o), VW'(0));
    chk({t, "_last"}, VW'(last_o), VW'(0));
    chk({t, "_win"}, windows_o, '0);
  endtask

  task automatic stall_ctl();
    logic [VW-1:0] hw;
    logic hl;
    int b = 0;
    do begin @(posedge clk_i); #1; b++; end while (!valid_o && b < 200);
    if (!valid_o) begin
      total++; bad++;
      $display("FAIL stall_start act=valid_o=0 req=valid_o=1");
    end
    ready_i = 1'b0;
    hw = windows_o;
    hl = last_o;
    repeat (3) begin
      @(negedge clk_i);
      chk("stall_win", windows_o, hw);
      chk("stall_last", VW'(last_o), VW'(hl));
      chk("stall_ready", VW'(ready_o), VW'(0));
    end
    @(posedge clk_i); #1;
    ready_i = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog act=running req=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk_i);
    check_reset_outputs("reset");
    @(posedge clk_i); #1;
    rst_ni = 1'b1;

    got.delete(); got_last.delete();
    frame(0, 0);
    drain_and_check("t1", 4);

    got.delete(); got_last.delete();
    fork
      frame(0, 0);
      stall_ctl();
    join
    drain_and_check("t2", 4);

    got.delete(); got_last.delete();
    frame(0, 1);
    drain_and_check("t3", 4);

    got.delete(); got_last.delete();
    frame(0, 0);
    frame(100, 0);
    drain_and_check("t4", 8);
    chk("t4_fifth", VW'(got[4]), VW'(pack9(w_first, 100)));
    chk("t4_eighth", VW'(got[7]), VW'(pack9(w_last, 100)));
    chk("t4_eighthflag", VW'(got_last[7]), VW'(1));

    for (int p = 0; p < 9; p++) send(p, 0);
    @(posedge clk_i); #1;
    rst_ni = 1'b0;
    check_reset_outputs("midreset");
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    got.delete(); got_last.delete();
    frame(0, 0);
    drain_and_check("t5", 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
